// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous sram32 macro.
// Grants are combinational; read data is routed back one cycle after the read edge.
module sram_port_arbiter #(
    parameter int unsigned AW        = 10,
    parameter int unsigned PRIO_MODE = 0,
    parameter int unsigned MAX_LOCK  = 16
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          r0_req,
    input  logic          r0_lock,
    input  logic [3:0]    r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [31:0]   r0_wdata,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [31:0]   r0_rdata,
    input  logic          r1_req,
    input  logic          r1_lock,
    input  logic [3:0]    r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [31:0]   r1_wdata,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [31:0]   r1_rdata,
    output logic          sram_cs,
    output logic [3:0]    sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata,
    output logic [1:0]    owner
);

    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            last_grant, last_grant_nxt;
    logic [CW-1:0]   lock_cnt, lock_cnt_nxt, lock_inc;
    logic            guard, guard_nxt;
    logic            rd_pend, rd_port;
    logic [AW-1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic            gnt0, gnt1;
    logic            own1, req_p, lock_p;

    // State register; guard marks the cycle right after a forced lock release.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state      <= FREE;
            last_grant <= 1'b1;
            lock_cnt   <= '0;
            guard      <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            lock_cnt   <= lock_cnt_nxt;
            guard      <= guard_nxt;
        end
    end

    // Arbitration and next-state.
    always_comb begin
        gnt0           = 1'b0;
        gnt1           = 1'b0;
        state_nxt      = state;
        last_grant_nxt = last_grant;
        lock_cnt_nxt   = lock_cnt;
        guard_nxt      = 1'b0;
        own1           = (state == LOCK1);
        req_p          = own1 ? r1_req  : r0_req;
        lock_p         = own1 ? r1_lock : r0_lock;
        lock_inc       = (lock_cnt == {CW{1'b1}}) ? lock_cnt : lock_cnt + CW'(1);
        case (state)
            FREE: begin
                if (r0_req && r1_req) begin
                    if ((PRIO_MODE != 0) && !guard) begin
                        gnt0 = 1'b1;
                    end else begin
                        gnt0 = last_grant;
                        gnt1 = ~last_grant;
                    end
                end else begin
                    gnt0 = r0_req;
                    gnt1 = r1_req;
                end
                if (gnt0 || gnt1) begin
                    last_grant_nxt = gnt1;
                    if (gnt1 ? r1_lock : r0_lock) begin
                        state_nxt    = gnt1 ? LOCK1 : LOCK0;
                        lock_cnt_nxt = CW'(1);
                    end
                end
            end
            LOCK0, LOCK1: begin
                if (!req_p) begin
                    state_nxt    = FREE;
                    lock_cnt_nxt = '0;
                end else begin
                    gnt0           = ~own1;
                    gnt1           = own1;
                    last_grant_nxt = own1;
                    if (!lock_p) begin
                        state_nxt    = FREE;
                        lock_cnt_nxt = '0;
                    end else if (lock_inc >= CW'(MAX_LOCK)) begin
                        state_nxt    = FREE;
                        lock_cnt_nxt = '0;
                        guard_nxt    = 1'b1;
                    end else begin
                        lock_cnt_nxt = lock_inc;
                    end
                end
            end
            default: begin
                state_nxt    = FREE;
                lock_cnt_nxt = '0;
            end
        endcase
        if (HRESET) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    // Read-return tracking and address/data hold registers.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            rd_pend <= 1'b0;
            rd_port <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            rd_pend <= sram_cs && (sram_we == 4'b0000);
            rd_port <= gnt1;
            addr_q  <= sram_addr;
            wdata_q <= sram_wdata;
        end
    end

    assign r0_gnt     = gnt0;
    assign r1_gnt     = gnt1;
    assign sram_cs    = gnt0 | gnt1;
    assign sram_we    = gnt1 ? r1_we    : (gnt0 ? r0_we    : 4'b0000);
    assign sram_addr  = gnt1 ? r1_addr  : (gnt0 ? r0_addr  : addr_q);
    assign sram_wdata = gnt1 ? r1_wdata : (gnt0 ? r0_wdata : wdata_q);
    assign r0_rvalid  = rd_pend & ~rd_port;
    assign r1_rvalid  = rd_pend & rd_port;
    assign r0_rdata   = r0_rvalid ? sram_rdata : 32'h0;
    assign r1_rdata   = r1_rvalid ? sram_rdata : 32'h0;
    assign owner      = (state == LOCK0) ? 2'b01 : ((state == LOCK1) ? 2'b10 : 2'b00);

endmodule
